// File: rtl/rsa_pkg.sv
// rtl/rsa_pkg.sv - shared types, defaults and helpers for the RSA key-generation blocks
package rsa_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_GEN, S_EXP_INIT, S_SQ, S_MUL, S_CHECK, S_DONE
  } state_t;

  // Narrower instances take the low bits of this seed unless overridden.
  localparam logic [127:0] DEFAULT_SEED = 128'hABCDEFABCDEF1234;

  function automatic logic [127:0] default_taps(input int width);
    case (width)
      16:      return 128'hB400;
      32:      return 128'h80200003;
      default: return 128'hD800000000000000;
    endcase
  endfunction

  function automatic int max_base(input int rounds);
    return rounds + 1;
  endfunction

endpackage

// File: rtl/mod_mul_serial.sv
// rtl/mod_mul_serial.sv - serial interleaved shift-add modular multiplier, result = a*b mod n
module mod_mul_serial #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] n,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH+1:0] acc, step, red1, red;
  logic [WIDTH-1:0] a_q, b_q, n_q;
  logic [CW-1:0]    cnt;
  logic             run;

  // acc < n and a < n, so 2*acc + a < 3n: two conditional subtractions suffice.
  always_comb begin
    step = {acc[WIDTH:0], 1'b0} + (b_q[WIDTH-1] ? {2'b00, a_q} : '0);
    red1 = (step >= {2'b00, n_q}) ? step - {2'b00, n_q} : step;
    red  = (red1 >= {2'b00, n_q}) ? red1 - {2'b00, n_q} : red1;
  end

  // done and result are valid in the final iteration cycle so the caller can chain ops back to back.
  assign done   = run && (cnt == CW'(1));
  assign result = red[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      run <= 1'b0;
      cnt <= '0;
      acc <= '0;
      a_q <= '0;
      b_q <= '0;
      n_q <= '0;
    end else if (start) begin
      run <= 1'b1;
      cnt <= CW'(WIDTH);
      acc <= '0;
      a_q <= a;
      b_q <= b;
      n_q <= n;
    end else if (run) begin
      acc <= red;
      b_q <= b_q << 1;
      cnt <= cnt - CW'(1);
      if (cnt == CW'(1)) run <= 1'b0;
    end
  end

endmodule

// File: rtl/prime_search_engine.sv
// rtl/prime_search_engine.sv - LFSR-driven or external-candidate Fermat prime search
module prime_search_engine
  import rsa_pkg::*;
#(
  parameter int               WIDTH     = 64,
  parameter int               ROUNDS    = 4,
  parameter int               MAX_TRIES = 1024,
  parameter logic [WIDTH-1:0] TAPS      = WIDTH'(default_taps(WIDTH)),
  parameter logic [WIDTH-1:0] SEED      = WIDTH'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] cand_in,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [WIDTH-1:0] prime_out,
  output logic [15:0]      tries
);
  localparam logic [WIDTH-1:0] SEED_NZ  = (SEED == '0) ? WIDTH'(1) : SEED;
  localparam logic [WIDTH-1:0] SHAPE    = {1'b1, {(WIDTH-2){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MAX_BASE = WIDTH'(max_base(ROUNDS));
  localparam int               ECW      = $clog2(WIDTH + 1);

  state_t           state;
  logic             mode_q, pass, mul_start, mul_done;
  logic [WIDTH-1:0] lfsr, lfsr_next, cand, r, e, mul_b, mul_result;
  logic [ECW-1:0]   ebits;
  logic [2:0]       round;
  logic [31:0]      try_cnt;

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);
  assign mul_b     = (state == S_MUL) ? WIDTH'(round) + WIDTH'(2) : r;

  mod_mul_serial #(.WIDTH(WIDTH)) u_mul (
    .clk    (clk),
    .reset  (reset),
    .start  (mul_start),
    .a      (r),
    .b      (mul_b),
    .n      (cand),
    .done   (mul_done),
    .result (mul_result)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      lfsr      <= SEED_NZ;
      busy      <= 1'b0;
      done      <= 1'b0;
      found     <= 1'b0;
      prime_out <= '0;
      tries     <= '0;
      try_cnt   <= '0;
      mode_q    <= 1'b0;
      pass      <= 1'b0;
      mul_start <= 1'b0;
      cand      <= '0;
      r         <= '0;
      e         <= '0;
      ebits     <= '0;
      round     <= '0;
    end else begin
      done      <= 1'b0;
      mul_start <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          mode_q  <= mode;
          found   <= 1'b0;
          tries   <= '0;
          try_cnt <= '0;
          busy    <= 1'b1;
          state   <= S_GEN;
        end
        S_GEN: begin
          tries   <= (tries == 16'hFFFF) ? tries : tries + 16'd1;
          try_cnt <= try_cnt + 32'd1;
          round   <= '0;
          if (mode_q) begin
            cand <= cand_in;
            if (!cand_in[0] || cand_in <= MAX_BASE) begin
              pass  <= 1'b0;
              state <= S_DONE;
            end else begin
              state <= S_EXP_INIT;
            end
          end else begin
            lfsr  <= lfsr_next;
            cand  <= lfsr_next | SHAPE;
            state <= S_EXP_INIT;
          end
        end
        S_EXP_INIT: begin
          r         <= WIDTH'(1);
          e         <= cand - WIDTH'(1);
          ebits     <= ECW'(WIDTH);
          mul_start <= 1'b1;
          state     <= S_SQ;
        end
        // Exponent scanned MSB first; a set bit inserts a multiply by the base after the square.
        S_SQ, S_MUL: if (mul_done) begin
          r <= mul_result;
          if (state == S_SQ && e[WIDTH-1]) begin
            mul_start <= 1'b1;
            state     <= S_MUL;
          end else begin
            e     <= e << 1;
            ebits <= ebits - ECW'(1);
            if (ebits == ECW'(1)) begin
              state <= S_CHECK;
            end else begin
              mul_start <= 1'b1;
              state     <= S_SQ;
            end
          end
        end
        S_CHECK: begin
          if (r == WIDTH'(1)) begin
            if (32'(round) < 32'(ROUNDS - 1)) begin
              round <= round + 3'd1;
              state <= S_EXP_INIT;
            end else begin
              pass  <= 1'b1;
              state <= S_DONE;
            end
          end else if (!mode_q && try_cnt < 32'(MAX_TRIES)) begin
            state <= S_GEN;
          end else begin
            pass  <= 1'b0;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          found     <= pass;
          prime_out <= cand;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
